// File: rtl/hilo_register_unit_pkg.sv
// Shared defaults and types for the HI/LO register unit.
// Widths, reset values and the pipeline slot record used by the top and its slots.
package hilo_register_unit_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned HILO_WIDTH         = 2 * DEFAULT_DATA_WIDTH;
    localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_RESET_HI = '0;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_RESET_LO = '0;

    typedef struct packed {
        logic                          v;
        logic [DEFAULT_DATA_WIDTH-1:0] hi;
        logic [DEFAULT_DATA_WIDTH-1:0] lo;
    } hilo_slot_t;

    function automatic logic [HILO_WIDTH-1:0] slot_hilo(input hilo_slot_t s);
        return {s.hi, s.lo};
    endfunction

endpackage

// File: rtl/hilo_pipe_slot.sv
// One valid+data pipeline register for an in-flight HI/LO write.
// hold freezes the slot; clear kills the valid bit even while held.
module hilo_pipe_slot #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hold_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    logic                  v_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q  <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (hold_i) begin
            // A held slot can still be turned into a bubble.
            if (clear_i) begin
                v_q <= 1'b0;
            end
        end else begin
            v_q  <= valid_i & ~clear_i;
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    assign valid_o = v_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/hilo_register_unit.sv
// Architectural HI/LO registers with MEM/WB write slots, forwarding and commit counter.
// Define HILO_BYPASS_EN to forward in-flight writes; otherwise Hazard stalls EX until drained.
module hilo_register_unit
    import hilo_register_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_HI   = DATA_WIDTH'(DEFAULT_RESET_HI),
    parameter logic [DATA_WIDTH-1:0] RESET_LO   = DATA_WIDTH'(DEFAULT_RESET_LO),
    parameter int unsigned           CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic                    Write,
    input  logic [DATA_WIDTH-1:0]   Hi,
    input  logic [DATA_WIDTH-1:0]   Lo,
    output logic [2*DATA_WIDTH-1:0] HiLo,
    output logic                    Pending,
    output logic                    Hazard,
    output logic [CNT_WIDTH-1:0]    WriteCount
);

    logic                  mem_v;
    logic [DATA_WIDTH-1:0] mem_hi;
    logic [DATA_WIDTH-1:0] mem_lo;
    logic                  wb_v;
    logic [DATA_WIDTH-1:0] wb_hi;
    logic [DATA_WIDTH-1:0] wb_lo;

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    hilo_pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_slot (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .hold_i  (Stall),
        .clear_i (Flush),
        .valid_i (Write),
        .hi_i    (Hi),
        .lo_i    (Lo),
        .valid_o (mem_v),
        .hi_o    (mem_hi),
        .lo_o    (mem_lo)
    );

    // Flush only ever targets the EX capture, so the WB slot is never cleared.
    hilo_pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_slot (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .hold_i  (Stall),
        .clear_i (1'b0),
        .valid_i (mem_v),
        .hi_i    (mem_hi),
        .lo_i    (mem_lo),
        .valid_o (wb_v),
        .hi_o    (wb_hi),
        .lo_o    (wb_lo)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hi_q  <= RESET_HI;
            lo_q  <= RESET_LO;
            cnt_q <= '0;
        end else if (!Stall && wb_v) begin
            hi_q  <= wb_hi;
            lo_q  <= wb_lo;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign Pending    = mem_v | wb_v;
    assign WriteCount = cnt_q;

`ifdef HILO_BYPASS_EN
    // Youngest in-flight write wins.
    always_comb begin
        HiLo = {hi_q, lo_q};
        if (mem_v) begin
            HiLo = {mem_hi, mem_lo};
        end else if (wb_v) begin
            HiLo = {wb_hi, wb_lo};
        end
    end

    assign Hazard = 1'b0;
`else
    assign HiLo   = {hi_q, lo_q};
    assign Hazard = Pending;
`endif

endmodule

// File: tb/tb_hilo_register_unit.sv
// Directed self-checking bench for hilo_register_unit, with and without HILO_BYPASS_EN.
module tb_hilo_register_unit;

`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          Clk;
    logic          Rst;
    logic          Stall;
    logic          Flush;
    logic          Write;
    logic [DW-1:0] Hi;
    logic [DW-1:0] Lo;
    logic [2*DW-1:0] HiLo;
    logic          Pending;
    logic          Hazard;
    logic [CW-1:0] WriteCount;

    int checks = 0;
    int errors = 0;

    hilo_register_unit #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Stall      (Stall),
        .Flush      (Flush),
        .Write      (Write),
        .Hi         (Hi),
        .Lo         (Lo),
        .HiLo       (HiLo),
        .Pending    (Pending),
        .Hazard     (Hazard),
        .WriteCount (WriteCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] hilo, input logic pend,
                             input logic haz, input logic [CW-1:0] cnt);
        check({tag, ".HiLo"}, HiLo, hilo);
        check({tag, ".Pending"}, {63'd0, Pending}, {63'd0, pend});
        check({tag, ".Hazard"}, {63'd0, Hazard}, {63'd0, haz});
        check({tag, ".WriteCount"}, {60'd0, WriteCount}, {60'd0, cnt});
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] h, input logic [DW-1:0] l);
        Write = w;
        Hi    = h;
        Lo    = l;
    endtask

    localparam logic [63:0] DB = 64'hDEADBEEF_00000005;
    localparam logic [63:0] AB = 64'h00000001_00000002;
    localparam logic [63:0] BB = 64'h00000003_00000004;
    localparam logic [63:0] SB = 64'h00000007_00000008;
    localparam logic [63:0] P9 = 64'h00000009_0000000A;

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(1'b0, '0, '0);
        #2;
        check_all("reset", 64'd0, 1'b0, 1'b0, 4'd0);
        #10 Rst = 1'b0;

        // Single write latency
        drive(1'b1, 32'hDEADBEEF, 32'h00000005);
        tick();
        drive(1'b0, 32'h12345678, 32'h9ABCDEF0);
        check_all("single.e0", BYP ? DB : 64'd0, 1'b1, !BYP, 4'd0);
        tick();
        check_all("single.e1", BYP ? DB : 64'd0, 1'b1, !BYP, 4'd0);
        tick();
        check_all("single.e2", DB, 1'b0, 1'b0, 4'd1);

        // Back-to-back forwarding: MEM beats WB
        drive(1'b1, 32'd1, 32'd2);
        tick();
        check_all("b2b.e0", BYP ? AB : DB, 1'b1, !BYP, 4'd1);
        drive(1'b1, 32'd3, 32'd4);
        tick();
        drive(1'b0, '0, '0);
        check_all("b2b.e1", BYP ? BB : DB, 1'b1, !BYP, 4'd1);
        tick();
        check_all("b2b.e2", BYP ? BB : AB, 1'b1, !BYP, 4'd2);
        tick();
        check_all("b2b.e3", BB, 1'b0, 1'b0, 4'd3);

        // Flush kills the EX capture
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        Flush = 1'b1;
        tick();
        drive(1'b0, '0, '0);
        Flush = 1'b0;
        check_all("flush.e0", BB, 1'b0, 1'b0, 4'd3);
        tick();
        tick();
        check_all("flush.e2", BB, 1'b0, 1'b0, 4'd3);

        // Stall holds slots and committed state
        drive(1'b1, 32'd7, 32'd8);
        tick();
        drive(1'b1, 32'hBAD0BAD0, 32'hBAD1BAD1);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall.hold", BYP ? SB : BB, 1'b1, !BYP, 4'd3);
        end
        drive(1'b0, '0, '0);
        Stall = 1'b0;
        tick();
        check_all("stall.rel1", BYP ? SB : BB, 1'b1, !BYP, 4'd3);
        tick();
        check_all("stall.rel2", SB, 1'b0, 1'b0, 4'd4);

        // Flush during stall bubbles MEM while WB holds
        drive(1'b1, 32'd9, 32'd10);
        tick();
        drive(1'b1, 32'd11, 32'd12);
        tick();
        drive(1'b0, '0, '0);
        Stall = 1'b1;
        Flush = 1'b1;
        tick();
        Stall = 1'b0;
        Flush = 1'b0;
        check_all("stallflush.e0", BYP ? P9 : SB, 1'b1, !BYP, 4'd4);
        tick();
        check_all("stallflush.e1", P9, 1'b0, 1'b0, 4'd5);
        tick();
        check_all("stallflush.e2", P9, 1'b0, 1'b0, 4'd5);

        // Eleven back-to-back writes wrap the 4-bit counter from 5 to 0
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 32'(i), ~32'(i));
            tick();
        end
        drive(1'b0, '0, '0);
        tick();
        check_all("wrap.e1", BYP ? {32'd10, ~32'd10} : {32'd9, ~32'd9}, 1'b1, !BYP, 4'd15);
        tick();
        check_all("wrap.e2", {32'd10, ~32'd10}, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h11111111, 32'h22222222);
        tick();
        tick();
        #2 Rst = 1'b1;
        #1;
        check_all("rstmid.in", 64'd0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, '0, '0);
        #3 Rst = 1'b0;
        tick();
        tick();
        tick();
        check_all("rstmid.after", 64'd0, 1'b0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
